// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with valid/ready handshake and one registered output stage.
// Define RR_MUX_HOLD_EN to add in_last and lock arbitration to one channel for a whole packet.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SEL_W = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
`ifdef RR_MUX_HOLD_EN
  input  logic [NCH-1:0]       in_last,
`endif
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_sel
);

  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [SEL_W-1:0] out_sel_r;
  logic [SEL_W-1:0] rr_ptr_r;

  logic             load_s;
  logic [NCH-1:0]   eligible_s;
  logic [NCH-1:0]   rot_s;
  logic [SEL_W-1:0] off_s;
  logic [SEL_W:0]   sum_s;
  logic [SEL_W-1:0] gidx_s;
  logic             any_s;
  logic [NCH-1:0]   grant_s;
  logic [SEL_W-1:0] next_ptr_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             last_s;

  assign load_s = !out_valid_r || out_ready;

`ifdef RR_MUX_HOLD_EN
  logic             lock_r;
  logic [SEL_W-1:0] lock_ch_r;
  logic [NCH-1:0]   lock_mask_s;

  // While a packet is in flight only its channel may win arbitration.
  always_comb begin
    lock_mask_s = '0;
    for (int i = 0; i < NCH; i++) begin
      lock_mask_s[i] = (lock_ch_r == SEL_W'(i));
    end
    if (lock_r) begin
      eligible_s = in_valid & lock_mask_s;
    end else begin
      eligible_s = in_valid;
    end
  end

  // Last-beat flag of the granted channel.
  always_comb begin
    last_s = |(grant_s & in_last);
  end

  // Packet lock: set on a non-last accepted beat, cleared by its last beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_r    <= 1'b0;
      lock_ch_r <= '0;
    end else if (load_s && any_s) begin
      if (!last_s) begin
        lock_r    <= 1'b1;
        lock_ch_r <= gidx_s;
      end else begin
        lock_r    <= 1'b0;
        lock_ch_r <= lock_ch_r;
      end
    end
  end
`else
  // Every beat is arbitrated on its own.
  always_comb begin
    eligible_s = in_valid;
    last_s     = 1'b1;
  end
`endif

  // Rotate requests so the priority search starts at rr_ptr, then map the winner back.
  always_comb begin
    rot_s = NCH'({eligible_s, eligible_s} >> rr_ptr_r);
    off_s = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = SEL_W'(k);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, rr_ptr_r} + {1'b0, off_s};
    if (sum_s >= (SEL_W+1)'(NCH)) begin
      gidx_s = SEL_W'(sum_s - (SEL_W+1)'(NCH));
    end else begin
      gidx_s = sum_s[SEL_W-1:0];
    end
    any_s   = |rot_s;
    grant_s = '0;
    for (int i = 0; i < NCH; i++) begin
      grant_s[i] = any_s && (gidx_s == SEL_W'(i));
    end
  end

  // Data of the granted channel and the pointer just past it.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_s[i]) begin
        sel_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
    if (gidx_s == SEL_W'(NCH - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gidx_s + SEL_W'(1);
    end
  end

  // Handshake back to producers; forced low while reset is asserted.
  always_comb begin
    if (!reset_n) begin
      in_ready = '0;
    end else if (load_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = '0;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_sel_r   <= '0;
      rr_ptr_r    <= '0;
    end else if (load_s) begin
      if (any_s) begin
        out_data_r  <= sel_data_s;
        out_sel_r   <= gidx_s;
        out_valid_r <= 1'b1;
        if (last_s) begin
          rr_ptr_r <= next_ptr_s;
        end
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized traffic
// against a cycle-level reference model built from modular arithmetic over channel indices.
module tb_rr_arb_mux;
  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SEL_W = 5;
`ifdef RR_MUX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_last;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_W-1:0]     out_sel;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_ptr;
  bit               m_lock;
  int               m_lockch;
  int               acc_ch;
  int               wait_b[NCH];

  rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SEL_W(SEL_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
`ifdef RR_MUX_HOLD_EN
    .in_last  (in_last),
`endif
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sel  (out_sel)
  );

  initial forever #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_sel    = 0;
    m_ptr    = 0;
    m_lock   = 1'b0;
    m_lockch = 0;
    acc_ch   = -1;
  endtask

  // first eligible channel scanning upward from the pointer with wrap, -1 if none
  function automatic int pick();
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (in_valid[c] && (!m_lock || c == m_lockch)) return c;
    end
    return -1;
  endfunction

  // one clock cycle: called at a falling edge with inputs already driven
  task automatic step();
    int g;
    bit ld;
    bit lst;
    logic [NCH-1:0]   exp_rdy;
    logic [WIDTH-1:0] gd;
    #1;
    ld      = !m_valid || out_ready;
    g       = pick();
    exp_rdy = '0;
    gd      = '0;
    lst     = 1'b1;
    if (g >= 0) begin
      gd  = in_data[g*WIDTH +: WIDTH];
      lst = in_last[g];
      if (ld) exp_rdy[g] = 1'b1;
    end
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    check_eq("out_data", 64'(out_data), 64'(m_data));
    check_eq("out_sel", 64'(out_sel), 64'(m_sel));
    @(posedge clock);
    acc_ch = -1;
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = gd;
        m_sel   = g;
        acc_ch  = g;
        if (HOLD && !lst) begin
          m_lock   = 1'b1;
          m_lockch = g;
        end else begin
          m_lock = 1'b0;
          m_ptr  = (g + 1) % NCH;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_ready", 64'(in_ready), 64'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int exp6[4];
    int b1;
    bit hit;
    logic [NCH-1:0] vbefore;
    if (HOLD) begin
      exp6[0] = 1; exp6[1] = 1; exp6[2] = 1; exp6[3] = 2;
    end else begin
      exp6[0] = 1; exp6[1] = 2; exp6[2] = 0; exp6[3] = 1;
    end

    reset_n   = 1'b0;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = 32'hA0 + i;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    #1;
    check_eq("init_valid", 64'(out_valid), 64'd0);
    check_eq("init_data", 64'(out_data), 64'd0);
    check_eq("init_sel", 64'(out_sel), 64'd0);
    check_eq("init_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // round robin with all channels valid
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq("t2_sel", 64'(out_sel), 64'((k - 1) % 4));
      check_eq("t2_data", 64'(out_data), 64'(32'hA0 + (k - 1) % 4));
    end

    // backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t3_sel", 64'(out_sel), 64'd3);
      check_eq("t3_data", 64'(out_data), 64'h0A3);
      check_eq("t3_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check_eq("t3_resume", 64'(out_sel), 64'd0);

    // asynchronous reset mid-stream
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t1_valid", 64'(out_valid), 64'd0);
    check_eq("t1_ready", 64'(in_ready), 64'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check_eq("t1_first", 64'(out_sel), 64'd0);
    check_eq("t1_fvalid", 64'(out_valid), 64'd1);

    // sparse request and pointer wrap
    in_valid = 4'b0100;
    step();
    check_eq("t4_sel2", 64'(out_sel), 64'd2);
    in_valid = 4'b0010;
    step();
    check_eq("t4_wrap", 64'(out_sel), 64'd1);
    in_valid = 4'b0000;
    step();
    check_eq("t4_drain", 64'(out_valid), 64'd0);
    in_valid = 4'b1011;
    step();
    check_eq("t4_ptr", 64'(out_sel), 64'd3);
    in_valid = 4'b0000;
    step();

    // fairness: ch2 must get through while ch0 streams
    in_valid = 4'b0001;
    step();
    step();
    in_valid = 4'b0101;
    hit = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      if (acc_ch == 2) in_valid[2] = 1'b0;
      if (out_valid && out_sel == 5'd2) hit = 1'b1;
    end
    check_eq("t5_fair", 64'(hit), 64'd1);
    in_valid = 4'b0000;
    step();

    // randomized traffic honouring the hold-until-accepted rule
    for (int i = 0; i < NCH; i++) wait_b[i] = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!in_valid[i] && $urandom_range(0, 2) != 0) begin
          in_valid[i] = 1'b1;
          in_data[i*WIDTH +: WIDTH] = $urandom;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      vbefore = in_valid;
      step();
      if (acc_ch >= 0) begin
        check_eq("fair_wait", 64'(wait_b[acc_ch] < NCH), 64'd1);
        wait_b[acc_ch] = 0;
        in_valid[acc_ch] = 1'b0;
        for (int i = 0; i < NCH; i++) begin
          if (vbefore[i] && i != acc_ch) wait_b[i]++;
        end
      end
    end

    // multi-beat packet on ch1 competing with ch0/ch2
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    #2;
    do_reset();
    in_valid = 4'b0001;
    step();
    in_valid = 4'b0111;
    in_last  = 4'b1101;
    b1 = 0;
    in_data[1*WIDTH +: WIDTH] = 32'h100;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("t6_seq", 64'(out_sel), 64'(exp6[k]));
      if (acc_ch == 1) begin
        b1++;
        in_data[1*WIDTH +: WIDTH] = 32'h100 + b1;
        if (b1 == 2) in_last[1] = 1'b1;
        if (b1 == 3) in_valid[1] = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
